// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   dmem_state_e : responder FSM states (IDLE, WAIT, DONE)
//   F3_*         : RV32 load/store funct3 size/sign encodings
//   size_to_be   : byte-lane write mask for a store size and address offset
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Any funct3 that is not B or H writes the full word.
  function automatic logic [3:0] size_to_be(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3)
      F3_B:    be = 4'b0001 << addr_lo;
      F3_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: selects the addressed byte/half from a memory word and
// sign- or zero-extends it according to the load funct3.
// Ports:
//   i_word    in  32  raw word read from the array
//   i_addr_lo in  2   byte offset within the word
//   i_funct3  in  3   load size/sign (B, H, BU, HU; anything else = W)
//   o_data    out 32  formatted load data
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'h0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-stage data RAM with WAIT_STATES cycles of latency.
// Accepts one load/store at a time, stalls the pipeline until the access
// completes, writes byte/half/word lanes and returns formatted load data.
// Optional macro DMEM_MISALIGN_ERR_EN: misaligned H/W accesses raise err_o,
// suppress the store and return zero; otherwise low address bits are masked.
// Ports:
//   clk_i    in  1   clock
//   rst_n_i  in  1   synchronous active-low reset
//   req_i    in  1   access request, held while stall_o=1
//   we_i     in  1   1=store, 0=load
//   funct3_i in  3   size/sign
//   addr_i   in  32  byte address
//   wdata_i  in  32  right-aligned store data
//   stall_o  out 1   hold upstream pipeline (combinational)
//   done_o   out 1   access completes this cycle
//   rdata_o  out 32  load data, valid with done_o on loads
//   err_o    out 1   misaligned access (only with DMEM_MISALIGN_ERR_EN)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_BITS   = 12,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  localparam int unsigned IdxW  = ADDR_BITS - 2;
  localparam int unsigned Depth = 2 ** IdxW;

  dmem_state_e r_state, w_state_next;
  logic [3:0]            r_cnt, w_cnt_next;
  logic [ADDR_BITS-1:0]  r_addr;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [2:0]            r_funct3;
  logic [31:0]           r_mem [Depth];

  logic                  w_accept;
  logic                  w_is_byte, w_is_half, w_is_word;
  logic                  w_err;
  logic [ADDR_BITS-1:0]  w_eaddr;
  logic [IdxW-1:0]       w_idx;
  logic [3:0]            w_be;
  logic [31:0]           w_store_data;
  logic [31:0]           w_load;
  logic                  w_wr_en;
  logic                  w_unused_addr;

  // Upper address bits are deliberately ignored: addresses wrap.
  assign w_unused_addr = ^addr_i[DATA_WIDTH-1:ADDR_BITS];

  assign w_accept = (r_state == IDLE) && req_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_funct3 <= 3'b000;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr   <= addr_i[ADDR_BITS-1:0];
        r_we     <= we_i;
        r_wdata  <= wdata_i;
        r_funct3 <= funct3_i;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    stall_o      = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_i) begin
          stall_o      = 1'b1;
          w_cnt_next   = 4'(WAIT_STATES);
          w_state_next = (WAIT_STATES == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall_o    = 1'b1;
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_next = DONE;
      end
      DONE: begin
        // stall_o stays low so the pipeline advances exactly once.
        done_o       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // BU/HU are only meaningful for loads; as store encodings they act as W.
  assign w_is_byte = (r_funct3 == F3_B) || (!r_we && (r_funct3 == F3_BU));
  assign w_is_half = (r_funct3 == F3_H) || (!r_we && (r_funct3 == F3_HU));
  assign w_is_word = !w_is_byte && !w_is_half;

`ifdef DMEM_MISALIGN_ERR_EN
  assign w_err   = (w_is_half && r_addr[0]) || (w_is_word && (r_addr[1:0] != 2'b00));
  assign w_eaddr = r_addr;
`else
  assign w_err   = 1'b0;
  assign w_eaddr = {r_addr[ADDR_BITS-1:2],
                    w_is_word ? 2'b00 : {r_addr[1], r_addr[0] & ~w_is_half}};
`endif

  assign w_idx = w_eaddr[ADDR_BITS-1:2];
  assign w_be  = size_to_be(r_funct3, w_eaddr[1:0]);

  always_comb begin
    w_store_data = r_wdata;
    if (w_is_byte)      w_store_data = {4{r_wdata[7:0]}};
    else if (w_is_half) w_store_data = {2{r_wdata[15:0]}};
  end

  // Commit on the edge leaving DONE; a reset on that edge drops the store.
  assign w_wr_en = (r_state == DONE) && r_we && !w_err && rst_n_i;

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_store_data[8*b +: 8];
      end
    end
  end

  dmem_load_align u_load_align (
    .i_word    (r_mem[w_idx]),
    .i_addr_lo (w_eaddr[1:0]),
    .i_funct3  (r_funct3),
    .o_data    (w_load)
  );

  assign err_o   = (r_state == DONE) && w_err;
  assign rdata_o = ((r_state == DONE) && !r_we && !w_err) ? w_load : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: dut A uses WAIT_STATES=2, dut B uses
// WAIT_STATES=0. Stimulus pushes expected responses; monitors pop on done_o.
module tb_dmem_responder;

  localparam logic [2:0] B  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] W  = 3'b010;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n, req_a, req_b, we;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic        stall_a, done_a, err_a, stall_b, done_b, err_b;
  logic [31:0] rdata_a, rdata_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        is_load;
    int          id;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   seq = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_WIDTH(32), .ADDR_BITS(12), .WAIT_STATES(2)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req_a), .we_i(we), .funct3_i(f3),
    .addr_i(addr), .wdata_i(wdata), .stall_o(stall_a), .done_o(done_a),
    .rdata_o(rdata_a), .err_o(err_a)
  );

  dmem_responder #(.DATA_WIDTH(32), .ADDR_BITS(12), .WAIT_STATES(0)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req_b), .we_i(we), .funct3_i(f3),
    .addr_i(addr), .wdata_i(wdata), .stall_o(stall_b), .done_o(done_b),
    .rdata_o(rdata_b), .err_o(err_b)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (done_a === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done_a: got done_o=1, expected no pending access");
      end else begin
        e = q_a.pop_front();
        check32($sformatf("a%0d_err", e.id), {31'b0, err_a}, {31'b0, e.err});
        if (e.is_load || e.err) check32($sformatf("a%0d_rdata", e.id), rdata_a, e.rdata);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (done_b === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done_b: got done_o=1, expected no pending access");
      end else begin
        e = q_b.pop_front();
        check32($sformatf("b%0d_err", e.id), {31'b0, err_b}, {31'b0, e.err});
        if (e.is_load || e.err) check32($sformatf("b%0d_rdata", e.id), rdata_b, e.rdata);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the DONE cycle so that a
  // following call issues back-to-back.
  task automatic access(input bit sel, input logic w, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    int   stalls;
    bit   got;
    e.rdata   = exp_rd;
    e.err     = exp_err;
    e.is_load = !w;
    e.id      = seq;
    seq++;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
    we = w; f3 = fn; addr = a; wdata = d;
    if (sel) req_b = 1'b1;
    else     req_a = 1'b1;
    stalls = 0;
    got    = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((sel ? stall_b : stall_a) === 1'b1) stalls++;
      if ((sel ? done_b : done_a) === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL access%0d_timeout: got no done_o in 40 cycles, expected done_o", e.id);
    end
    check32($sformatf("access%0d_stall_cycles", e.id), stalls, sel ? 32'd1 : 32'd3);
    @(posedge clk);
    #1;
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; we = 1'b0; f3 = W; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("reset_stall_a", {31'b0, stall_a}, 32'd0);
    check32("reset_done_a",  {31'b0, done_a},  32'd0);
    check32("reset_rdata_a", rdata_a,          32'd0);
    check32("reset_err_a",   {31'b0, err_a},   32'd0);
    check32("reset_done_b",  {31'b0, done_b},  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Word store/load
    access(0, 1, W,  32'h10, 32'hDEADBEEF, 32'h0,        0);
    access(0, 0, W,  32'h10, 32'h0,        32'hDEADBEEF, 0);
    // Byte lane 3
    access(0, 1, B,  32'h13, 32'h00000080, 32'h0,        0);
    access(0, 0, B,  32'h13, 32'h0,        32'hFFFFFF80, 0);
    access(0, 0, BU, 32'h13, 32'h0,        32'h00000080, 0);
    access(0, 0, W,  32'h10, 32'h0,        32'h80ADBEEF, 0);
    // Upper half
    access(0, 1, W,  32'h20, 32'h11112222, 32'h0,        0);
    access(0, 1, H,  32'h22, 32'h00008001, 32'h0,        0);
    access(0, 0, H,  32'h22, 32'h0,        32'hFFFF8001, 0);
    access(0, 0, HU, 32'h22, 32'h0,        32'h00008001, 0);
    access(0, 0, W,  32'h20, 32'h0,        32'h80012222, 0);

    // Reset during WAIT drops the store
    access(0, 1, W,  32'h30, 32'hCAFEF00D, 32'h0,        0);
    we = 1'b1; f3 = W; addr = 32'h30; wdata = 32'h12345678; req_a = 1'b1;
    @(negedge clk);
    check32("abort_accept_stall", {31'b0, stall_a}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; req_a = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check32("abort_stall_low", {31'b0, stall_a}, 32'd0);
    check32("abort_done_low",  {31'b0, done_a},  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    access(0, 0, W,  32'h30, 32'h0,        32'hCAFEF00D, 0);

    // Zero wait states, back-to-back
    access(1, 1, W,  32'h40, 32'h00000055, 32'h0,        0);
    access(1, 0, W,  32'h40, 32'h0,        32'h00000055, 0);
    access(1, 1, W,  32'h44, 32'h00000066, 32'h0,        0);
    access(1, 0, W,  32'h44, 32'h0,        32'h00000066, 0);
    access(1, 0, W,  32'h40, 32'h0,        32'h00000055, 0);

    // Address wrap and misalignment
    access(0, 1, W,  32'h0,    32'hA5A55A5A, 32'h0,        0);
`ifdef DMEM_MISALIGN_ERR_EN
    access(0, 1, W,  32'h1002, 32'h0BADF00D, 32'h0,        1);
    access(0, 0, W,  32'h1002, 32'h0,        32'h0,        1);
    access(0, 0, W,  32'h0,    32'h0,        32'hA5A55A5A, 0);
    access(0, 0, H,  32'h23,   32'h0,        32'h0,        1);
`else
    access(0, 0, W,  32'h1002, 32'h0,        32'hA5A55A5A, 0);
    access(0, 1, W,  32'h1002, 32'h0BADF00D, 32'h0,        0);
    access(0, 0, W,  32'h0,    32'h0,        32'h0BADF00D, 0);
    access(0, 0, H,  32'h23,   32'h0,        32'hFFFF8001, 0);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("pending_a", q_a.size(), 32'd0);
    check32("pending_b", q_b.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
